// File: rtl/cpu_consts.sv
// Shared execute-stage constants: divider FSM states and divide op encodings.
package cpu_consts;

   localparam logic [3:0] OP_DIV  = 4'd4;
   localparam logic [3:0] OP_DIVU = 4'd5;
   localparam logic [3:0] OP_REM  = 4'd6;
   localparam logic [3:0] OP_REMU = 4'd7;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } div_state_t;

   function automatic logic is_signed_op(input logic [3:0] func);
      return (func == OP_DIV) || (func == OP_REM);
   endfunction

   function automatic logic is_rem_op(input logic [3:0] func);
      return (func == OP_REM) || (func == OP_REMU);
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem,quo} left, trial-subtract divisor.
module div_step #(
   parameter int W = 64
) (
   input  logic [W-1:0] rem_i,
   input  logic [W-1:0] quo_i,
   input  logic [W-1:0] div_i,
   output logic [W-1:0] rem_o,
   output logic [W-1:0] quo_o
);

   logic [W:0]   rem_sh;
   logic [W+1:0] trial;

   // Two guard bits keep the trial sign unambiguous even when the shifted remainder exceeds W bits.
   always_comb begin
      rem_sh = {rem_i, quo_i[W-1]};
      trial  = {1'b0, rem_sh} - {2'b00, div_i};
      if (!trial[W+1]) begin
         rem_o = trial[W-1:0];
         quo_o = {quo_i[W-2:0], 1'b1};
      end else begin
         rem_o = rem_sh[W-1:0];
         quo_o = {quo_i[W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/divide.sv
// Iterative radix-2 restoring divider (DIV/DIVU/REM/REMU and *W) with valid/ready, flush and result hold.
// Optional macro DIV_EARLY_OUT_EN: skip iterations when divisor is zero or |a| < |b|.
module divide
   import cpu_consts::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            div_valid_i,
   input  logic [XLEN-1:0] opr_a_i,
   input  logic [XLEN-1:0] opr_b_i,
   input  logic [3:0]      div_func_i,
   input  logic            word_op_i,
   output logic            div_ready_o,
   input  logic            div_ready_i,
   output logic [XLEN-1:0] div_res_o,
   output logic            div_res_valid_o,
   input  logic            flush_i
);

   div_state_t      state_q, state_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic [6:0]      cnt_q, cnt_d;
   logic            neg_quo_q, neg_quo_d;
   logic            neg_rem_q, neg_rem_d;
   logic            word_q, word_d;
   logic [3:0]      func_q, func_d;

   logic            accept;
   logic            signed_op;
   logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b, dividend;
   logic            sa, sb, b_zero;
   logic [XLEN-1:0] step_rem, step_quo;
   logic [XLEN-1:0] q_val, r_val, res_sel, res_fin;
`ifdef DIV_EARLY_OUT_EN
   logic            early_out;
`endif

   // Word ops extend [31:0] first so the sign bit always lands in bit XLEN-1.
   always_comb begin
      signed_op = is_signed_op(div_func_i);
      if (word_op_i) begin
         a_ext = signed_op ? {{(XLEN-32){opr_a_i[31]}}, opr_a_i[31:0]} : {{(XLEN-32){1'b0}}, opr_a_i[31:0]};
         b_ext = signed_op ? {{(XLEN-32){opr_b_i[31]}}, opr_b_i[31:0]} : {{(XLEN-32){1'b0}}, opr_b_i[31:0]};
      end else begin
         a_ext = opr_a_i;
         b_ext = opr_b_i;
      end
      sa       = signed_op & a_ext[XLEN-1];
      sb       = signed_op & b_ext[XLEN-1];
      abs_a    = sa ? -a_ext : a_ext;
      abs_b    = sb ? -b_ext : b_ext;
      b_zero   = (abs_b == '0);
      dividend = word_op_i ? {abs_a[31:0], 32'd0} : abs_a;
   end

   assign accept = div_valid_i & (state_q == S_IDLE) & ~flush_i;
`ifdef DIV_EARLY_OUT_EN
   assign early_out = b_zero | (abs_a < abs_b);
`endif

   div_step #(.W(XLEN)) u_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .div_i (dvs_q),
      .rem_o (step_rem),
      .quo_o (step_quo)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         cnt_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         word_q    <= 1'b0;
         func_q    <= '0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         cnt_q     <= cnt_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         word_q    <= word_d;
         func_q    <= func_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
`ifdef DIV_EARLY_OUT_EN
               state_d = early_out ? S_DONE : S_RUN;
`else
               state_d = S_RUN;
`endif
            end
         end
         S_RUN: begin
            if (flush_i)
               state_d = S_IDLE;
            else if (cnt_q == 7'd1)
               state_d = S_DONE;
         end
         S_DONE: begin
            if (flush_i || div_ready_i)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      cnt_d     = cnt_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      word_d    = word_q;
      func_d    = func_q;
      if (accept) begin
         rem_d     = '0;
         quo_d     = dividend;
         dvs_d     = abs_b;
         cnt_d     = word_op_i ? 7'd32 : 7'd64;
         neg_quo_d = (sa ^ sb) & ~b_zero;
         neg_rem_d = sa;
         word_d    = word_op_i;
         func_d    = div_func_i;
`ifdef DIV_EARLY_OUT_EN
         if (early_out) begin
            quo_d = b_zero ? '1 : '0;
            rem_d = abs_a;
         end
`endif
      end else if (state_q == S_RUN && !flush_i) begin
         rem_d = step_rem;
         quo_d = step_quo;
         cnt_d = cnt_q - 7'd1;
      end
   end

   // Sign fix-up and word sign-extension apply to the unsigned word ops too.
   always_comb begin
      div_ready_o     = (state_q == S_IDLE);
      div_res_valid_o = (state_q == S_DONE) & ~flush_i;
      q_val           = neg_quo_q ? -quo_q : quo_q;
      r_val           = neg_rem_q ? -rem_q : rem_q;
      res_sel         = is_rem_op(func_q) ? r_val : q_val;
      res_fin         = word_q ? {{(XLEN-32){res_sel[31]}}, res_sel[31:0]} : res_sel;
      div_res_o       = div_res_valid_o ? res_fin : '0;
   end

endmodule

// File: tb/tb_divide.sv
// Scoreboard bench for divide: stimulus pushes expected results, a negedge monitor checks each result.
module tb_divide;
   import cpu_consts::*;

   typedef struct {
      logic [63:0] res;
      int          lat;
      int          acc;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        div_valid_i = 1'b0;
   logic [63:0] opr_a_i = '0;
   logic [63:0] opr_b_i = '0;
   logic [3:0]  div_func_i = OP_DIV;
   logic        word_op_i = 1'b0;
   logic        div_ready_o;
   logic        div_ready_i = 1'b0;
   logic [63:0] div_res_o;
   logic        div_res_valid_o;
   logic        flush_i = 1'b0;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   bit   seen = 0;
   exp_t sb[$];

   divide #(.XLEN(64)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .div_valid_i     (div_valid_i),
      .opr_a_i         (opr_a_i),
      .opr_b_i         (opr_b_i),
      .div_func_i      (div_func_i),
      .word_op_i       (word_op_i),
      .div_ready_o     (div_ready_o),
      .div_ready_i     (div_ready_i),
      .div_res_o       (div_res_o),
      .div_res_valid_o (div_res_valid_o),
      .flush_i         (flush_i)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Latency counts the accept edge through the edge that raises valid.
   always @(negedge clk) begin
      exp_t e;
      if (!resetn || !div_res_valid_o) begin
         seen = 0;
      end else if (!seen) begin
         seen = 1;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_valid: got result %h expected no result", div_res_o);
         end else begin
            e = sb.pop_front();
            check_output(e.name, div_res_o, e.res);
            check_output({e.name, "_latency"}, 64'(cyc - e.acc + 1), 64'(e.lat));
         end
      end
   end

   task automatic apply_stimulus(input logic [63:0] a, input logic [63:0] b, input logic [3:0] func,
                                 input logic word, input bit push, input logic [63:0] exp, input string name);
      exp_t e;
      @(negedge clk);
      opr_a_i     = a;
      opr_b_i     = b;
      div_func_i  = func;
      word_op_i   = word;
      div_valid_i = 1'b1;
      check_output({name, "_ready"}, {63'd0, div_ready_o}, 64'd1);
      @(posedge clk);
      #1;
      div_valid_i = 1'b0;
      if (push) begin
         e.res  = exp;
         e.lat  = word ? 33 : 65;
         e.acc  = cyc;
         e.name = name;
         sb.push_back(e);
      end
   endtask

   task automatic wait_valid(input string name, output bit ok);
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (div_res_valid_o) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s_timeout: got no valid within 200 cycles expected valid", name);
      end
   endtask

   task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [3:0] func,
                         input logic word, input logic [63:0] exp, input string name, input int hold);
      bit ok;
      apply_stimulus(a, b, func, word, 1'b1, exp, name);
      wait_valid(name, ok);
      if (ok) begin
         for (int i = 0; i < hold; i++) begin
            check_output({name, "_hold_valid"}, {63'd0, div_res_valid_o}, 64'd1);
            check_output({name, "_hold_res"}, div_res_o, exp);
            @(negedge clk);
         end
      end
      #1 div_ready_i = 1'b1;
      @(posedge clk);
      #1 div_ready_i = 1'b0;
   endtask

   initial begin
      bit ok;
      repeat (3) @(negedge clk);
      check_output("reset_ready", {63'd0, div_ready_o}, 64'd1);
      check_output("reset_valid", {63'd0, div_res_valid_o}, 64'd0);
      check_output("reset_res", div_res_o, 64'd0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      run_op(-64'sd20, 64'd3, OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA, "div_m20_3", 0);
      run_op(-64'sd20, 64'd3, OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, "rem_m20_3", 0);
      run_op(64'h8000_0000_0000_0000, 64'd0, OP_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, "divu_by0", 0);
      run_op(64'h8000_0000_0000_0000, 64'd0, OP_REMU, 1'b0, 64'h8000_0000_0000_0000, "remu_by0", 0);
      run_op(64'd5, 64'd0, OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, "div_5_by0", 0);
      run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, OP_DIV, 1'b0, 64'h8000_0000_0000_0000, "div_min_m1", 0);
      run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, OP_REM, 1'b0, 64'd0, "rem_min_m1", 0);
      run_op(64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, OP_DIV, 1'b1, 64'hFFFF_FFFF_8000_0000, "divw_min_m1", 0);
      run_op(64'h0000_0000_FFFF_FFFF, 64'd1, OP_DIVU, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "divuw_max_1", 0);
      run_op(64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, OP_REM, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "remw_m7_2", 0);

      // Held result, then a back-to-back accept right after the handoff.
      run_op(64'd100, 64'd7, OP_DIVU, 1'b0, 64'd14, "divu_100_7_hold", 10);
      run_op(64'd100, 64'd7, OP_REMU, 1'b0, 64'd2, "remu_100_7_b2b", 0);

      apply_stimulus(64'd1000, 64'd9, OP_DIVU, 1'b0, 1'b0, 64'd0, "flush_run");
      repeat (19) @(posedge clk);
      @(negedge clk);
      flush_i = 1'b1;
      @(posedge clk);
      #1 flush_i = 1'b0;
      @(negedge clk);
      check_output("flush_run_ready", {63'd0, div_ready_o}, 64'd1);
      check_output("flush_run_valid", {63'd0, div_res_valid_o}, 64'd0);

      // Flush and writeback-ready together in S_DONE: flush wins, no handoff.
      apply_stimulus(64'd50, 64'd5, OP_DIVU, 1'b0, 1'b1, 64'd10, "flush_done");
      wait_valid("flush_done", ok);
      #1;
      flush_i     = 1'b1;
      div_ready_i = 1'b1;
      #1;
      check_output("flush_done_valid_masked", {63'd0, div_res_valid_o}, 64'd0);
      check_output("flush_done_res_masked", div_res_o, 64'd0);
      @(posedge clk);
      #1;
      flush_i     = 1'b0;
      div_ready_i = 1'b0;
      @(negedge clk);
      check_output("flush_done_ready", {63'd0, div_ready_o}, 64'd1);
      check_output("flush_done_valid", {63'd0, div_res_valid_o}, 64'd0);
      repeat (5) @(negedge clk);

      apply_stimulus(64'd77, 64'd7, OP_DIVU, 1'b0, 1'b0, 64'd0, "reset_mid");
      repeat (10) @(negedge clk);
      resetn = 1'b0;
      #1;
      check_output("reset_mid_ready", {63'd0, div_ready_o}, 64'd1);
      check_output("reset_mid_valid", {63'd0, div_res_valid_o}, 64'd0);
      check_output("reset_mid_res", div_res_o, 64'd0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      run_op(-64'sd20, 64'd3, OP_DIV, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, "divw_m20_3", 0);

      repeat (5) @(negedge clk);
      check_output("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
